// File: rtl/prbs9_ber_checker.sv
// PRBS9 bit-error-rate checker for one rail of the oversampled QPSK link.
// Decimates at a selectable phase, hard-slices, self-synchronises a local LFSR and counts errors.
module prbs9_ber_checker #(
    parameter int unsigned NBT_IN      = 8,
    parameter int unsigned OVERSAMP    = 4,
    parameter int unsigned NB_PHASE    = 2,
    parameter logic [8:0]  PRBS_SEED   = 9'h1AA,
    parameter int unsigned SYNC_LEN    = 128,
    parameter int unsigned SYNC_THRESH = 8,
    parameter int unsigned NB_CNT      = 48
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [NBT_IN-1:0]   i_sample,
    input  logic [NB_PHASE-1:0] i_phase,
    input  logic                i_resync,
    output logic                o_bit,
    output logic                o_bit_valid,
    output logic                o_err,
    output logic                o_locked,
    output logic [NB_CNT-1:0]   o_bit_count,
    output logic [NB_CNT-1:0]   o_err_count
);

    localparam int unsigned NB_WIN   = $clog2(SYNC_LEN + 1);
    localparam int unsigned NB_LOAD  = 4;
    localparam int unsigned THR_EFF  = (SYNC_THRESH > SYNC_LEN) ? SYNC_LEN : SYNC_THRESH;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0]          state, state_next;
    logic [NB_PHASE-1:0] pcnt;
    logic [8:0]          lfsr, lfsr_next;
    logic [NB_LOAD-1:0]  load_cnt, load_cnt_next;
    logic [NB_WIN-1:0]   win_cnt, win_cnt_next;
    logic [NB_WIN-1:0]   win_err, win_err_next;
    logic [NB_WIN-1:0]   win_err_sum;
    logic [NB_CNT-1:0]   bit_cnt_next, err_cnt_next;
    logic                bit_next, err_next, valid_next;
    logic                stb, rx_bit, fb, cmp_err;

    // Only the sign bit feeds the hard slicer; the magnitude bits are intentionally dropped.
    logic unused_sample;
    assign unused_sample = ^i_sample[NBT_IN-2:0];

    assign stb     = i_enable && (pcnt == i_phase);
    assign rx_bit  = i_sample[NBT_IN-1];
    assign fb      = lfsr[8] ^ lfsr[4];
    assign cmp_err = rx_bit ^ fb;
    assign win_err_sum = win_err + NB_WIN'(cmp_err);

    // Decimation phase counter, frozen while disabled.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            pcnt <= '0;
        end else if (i_enable) begin
            if (pcnt == NB_PHASE'(OVERSAMP - 1)) pcnt <= '0;
            else                                 pcnt <= pcnt + NB_PHASE'(1);
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) state <= ST_LOAD;
        else          state <= state_next;
    end

    // Next-state and datapath update; a resync wins over a coincident strobe.
    always_comb begin
        state_next    = state;
        lfsr_next     = lfsr;
        load_cnt_next = load_cnt;
        win_cnt_next  = win_cnt;
        win_err_next  = win_err;
        bit_cnt_next  = o_bit_count;
        err_cnt_next  = o_err_count;
        bit_next      = o_bit;
        err_next      = o_err;
        valid_next    = 1'b0;

        if (i_enable && i_resync) begin
            state_next    = ST_LOAD;
            load_cnt_next = '0;
        end else if (stb) begin
            valid_next = 1'b1;
            bit_next   = rx_bit;
            case (state)
                ST_LOAD: begin
                    lfsr_next = {lfsr[7:0], rx_bit};
                    err_next  = 1'b0;
                    if (load_cnt == NB_LOAD'(8)) begin
                        state_next    = ST_CHECK;
                        load_cnt_next = '0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else begin
                        load_cnt_next = load_cnt + NB_LOAD'(1);
                    end
                end
                ST_CHECK: begin
                    // Shift in the prediction so a single channel error costs exactly one count.
                    lfsr_next    = {lfsr[7:0], fb};
                    err_next     = cmp_err;
                    win_cnt_next = win_cnt + NB_WIN'(1);
                    win_err_next = win_err_sum;
                    if (win_cnt == NB_WIN'(SYNC_LEN - 1)) begin
                        if (win_err_sum <= NB_WIN'(THR_EFF)) begin
                            state_next   = ST_LOCKED;
                            bit_cnt_next = '0;
                            err_cnt_next = '0;
                        end else begin
                            state_next    = ST_LOAD;
                            load_cnt_next = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    lfsr_next = {lfsr[7:0], fb};
                    err_next  = cmp_err;
                    if (o_bit_count != {NB_CNT{1'b1}})
                        bit_cnt_next = o_bit_count + NB_CNT'(1);
                    if (cmp_err && (o_err_count != {NB_CNT{1'b1}}))
                        err_cnt_next = o_err_count + NB_CNT'(1);
                end
                default: begin
                    state_next    = ST_LOAD;
                    load_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            lfsr        <= PRBS_SEED;
            load_cnt    <= '0;
            win_cnt     <= '0;
            win_err     <= '0;
            o_bit       <= 1'b0;
            o_bit_valid <= 1'b0;
            o_err       <= 1'b0;
            o_locked    <= 1'b0;
            o_bit_count <= '0;
            o_err_count <= '0;
        end else begin
            lfsr        <= lfsr_next;
            load_cnt    <= load_cnt_next;
            win_cnt     <= win_cnt_next;
            win_err     <= win_err_next;
            o_bit       <= bit_next;
            o_bit_valid <= valid_next;
            o_err       <= err_next;
            o_locked    <= (state_next == ST_LOCKED);
            o_bit_count <= bit_cnt_next;
            o_err_count <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Directed bench for prbs9_ber_checker: clean lock, single flip, enable freeze, resync, garbage, saturation, reset.
module tb_prbs9_ber_checker;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic signed [7:0] sample;
    logic [1:0]        phase;
    logic              resync;
    logic              rx_bit_o, valid_o, err_o, locked_o;
    logic [47:0]       bit_count, err_count;

    logic              sat_bit, sat_valid, sat_err, sat_locked;
    logic [3:0]        sat_bc, sat_ec;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [8:0]  m;
    logic        obs_valid, obs_bit, obs_err, obs_locked;
    logic [47:0] obs_bc, obs_ec;

    always #5 clk = ~clk;

    prbs9_ber_checker dut (
        .clk(clk), .i_reset(rst_n), .i_enable(enable), .i_sample(sample),
        .i_phase(phase), .i_resync(resync), .o_bit(rx_bit_o), .o_bit_valid(valid_o),
        .o_err(err_o), .o_locked(locked_o), .o_bit_count(bit_count), .o_err_count(err_count)
    );

    // Constant "1" symbols against the self-running LFSR give a ~50% error stream once locked.
    prbs9_ber_checker #(.NB_CNT(4), .SYNC_THRESH(128)) sat_dut (
        .clk(clk), .i_reset(rst_n), .i_enable(1'b1), .i_sample(8'shA0),
        .i_phase(2'd0), .i_resync(1'b0), .o_bit(sat_bit), .o_bit_valid(sat_valid),
        .o_err(sat_err), .o_locked(sat_locked), .o_bit_count(sat_bc), .o_err_count(sat_ec)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic gen_bit(output logic b);
        b = m[8] ^ m[4];
        m = {m[7:0], b};
    endtask

    // One symbol held for 4 cycles starting at a strobe cycle; outputs captured one cycle later.
    task automatic send_sym(input logic b, input logic rs);
        sample = b ? 8'shA0 : 8'sh60;
        resync = rs;
        @(posedge clk);
        #1 resync = 1'b0;
        @(negedge clk);
        obs_valid  = valid_o;
        obs_bit    = rx_bit_o;
        obs_err    = err_o;
        obs_locked = locked_o;
        obs_bc     = bit_count;
        obs_ec     = err_count;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic b, nb;
        int unsigned errs, locked_seen, valid_seen;

        m = 9'h1AA;
        rst_n = 1'b0; enable = 1'b1; sample = 8'sh60; phase = 2'd0; resync = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bit", rx_bit_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_locked", locked_o, 0);
        check("rst_bc", bit_count, 0);
        check("rst_ec", err_count, 0);
        rst_n = 1'b1;

        // Clean link: lock exactly at the 137th strobe
        for (int k = 1; k <= 137; k++) begin
            gen_bit(b);
            send_sym(b, 1'b0);
            if (k == 1) begin
                check("first_valid", obs_valid, 1);
                check("first_bit", obs_bit, b);
                check("load_err", obs_err, 0);
            end
            if (k == 136) check("prelock", obs_locked, 0);
        end
        check("lock", obs_locked, 1);
        check("lock_bc", obs_bc, 0);

        errs = 0;
        for (int k = 0; k < 20; k++) begin
            gen_bit(b);
            send_sym(b, 1'b0);
            if (obs_err) errs++;
        end
        check("clean_err_bits", errs, 0);
        check("clean_bc", obs_bc, 20);
        check("clean_ec", obs_ec, 0);

        // Single symbol flip
        gen_bit(b);
        nb = ~b;
        send_sym(nb, 1'b0);
        check("flip_err", obs_err, 1);
        check("flip_bit", obs_bit, nb);
        check("flip_valid", obs_valid, 1);
        for (int k = 0; k < 10; k++) begin
            gen_bit(b);
            send_sym(b, 1'b0);
            if (k == 0) check("after_flip_err", obs_err, 0);
        end
        check("flip_bc", obs_bc, 31);
        check("flip_ec", obs_ec, 1);
        check("flip_locked", obs_locked, 1);

        // Enable held low 7 cycles starting on a strobe cycle
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("dis_valid", valid_o, 0);
            @(posedge clk);
        end
        #1;
        check("dis_bc", bit_count, 31);
        check("dis_ec", err_count, 1);
        enable = 1'b1;
        gen_bit(b);
        send_sym(b, 1'b0);
        check("reen_valid", obs_valid, 1);
        check("reen_bc", obs_bc, 32);

        // Resync coincident with a strobe, then relock
        gen_bit(b);
        send_sym(b, 1'b1);
        check("rs_locked", obs_locked, 0);
        check("rs_bc", obs_bc, 32);
        check("rs_ec", obs_ec, 1);
        for (int k = 1; k <= 137; k++) begin
            gen_bit(b);
            send_sym(b, 1'b0);
            if (k == 136) begin
                check("rs_prelock", obs_locked, 0);
                check("rs_held_bc", obs_bc, 32);
            end
        end
        check("relock", obs_locked, 1);
        check("relock_bc", obs_bc, 0);
        for (int k = 1; k <= 5; k++) begin
            gen_bit(b);
            send_sym(b, 1'b0);
            if (k == 1) begin
                check("relock_bc1", obs_bc, 1);
                check("relock_ec1", obs_ec, 0);
            end
        end
        check("relock_bc5", obs_bc, 5);

        check("sat_locked", sat_locked, 1);
        check("sat_bc", sat_bc, 4'hF);
        check("sat_ec", sat_ec, 4'hF);

        // Resync into LOAD with random bits: no errors reported while loading
        send_sym(1'b0, 1'b1);
        check("rs2_locked", obs_locked, 0);
        errs = 0;
        for (int k = 0; k < 9; k++) begin
            b = 1'($urandom_range(1, 0));
            send_sym(b, 1'b0);
            if (obs_err) errs++;
        end
        check("load_no_err", errs, 0);

        // Garbage at a different phase: never locks, one strobe per 4 cycles
        phase = 2'd2;
        locked_seen = 0;
        valid_seen  = 0;
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk);
            if (locked_o) locked_seen++;
            if (valid_o) valid_seen++;
            sample = 8'($urandom);
        end
        check("garbage_locked", locked_seen, 0);
        check("garbage_valids", valid_seen, 3000);
        check("garbage_bc_held", bit_count, 5);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_bc", bit_count, 0);
        check("arst_ec", err_count, 0);
        check("arst_locked", locked_o, 0);
        check("arst_valid", valid_o, 0);
        check("arst_sat_bc", sat_bc, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
